// File: rtl/lcd1602_bus_responder.sv
// Receive side of the 1602 character-LCD write bus: decodes commands and data
// into a shadow 2x16 DDRAM plus controller state, with a registered readback port.
module lcd1602_bus_responder #(
  parameter logic [7:0] BLANK_CHAR = 8'h20,
  parameter logic [6:0] ROW2_BASE  = 7'h40
) (
  input  logic       clk_2ms,
  input  logic       rst,
  input  logic       lcd_en_sel,
  input  logic       rs,
  input  logic       rw,
  input  logic [7:0] db,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [6:0] ac,
  output logic       disp_on,
  output logic       two_line,
  output logic       eight_bit,
  output logic       entry_inc,
  output logic       frame_done,
  output logic       unsup_cmd,
  output logic       bus_err
);

  // Two-line DDRAM map of the controller: 40 addresses per line.
  localparam logic [6:0] LINE1_LAST  = 7'h27;
  localparam logic [6:0] LINE2_FIRST = 7'h40;
  localparam logic [6:0] LINE2_LAST  = 7'h67;

  logic [7:0]  mem [0:31];
  logic [31:0] valid_q, valid_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic [6:0]  ac_q, ac_d;
  logic        disp_on_q, disp_on_d;
  logic        two_line_q, two_line_d;
  logic        eight_bit_q, eight_bit_d;
  logic        entry_inc_q, entry_inc_d;
  logic        frame_done_q, frame_done_d;
  logic        unsup_cmd_q, unsup_cmd_d;
  logic        bus_err_q, bus_err_d;

  logic       cmd_wr, data_wr, rw_err;
  logic [7:0] row2_off;
  logic       cell_hit;
  logic [4:0] cell_idx;
  logic [6:0] ac_step;

  assign cmd_wr  = lcd_en_sel & ~rw & ~rs;
  assign data_wr = lcd_en_sel & ~rw & rs;
  assign rw_err  = lcd_en_sel & rw;

  // Map the address counter onto one of the 32 visible cells; 8-bit subtract
  // keeps addresses below ROW2_BASE from aliasing into row 2.
  always_comb begin
    row2_off = {1'b0, ac_q} - {1'b0, ROW2_BASE};
    cell_hit = 1'b0;
    cell_idx = {1'b0, ac_q[3:0]};
    if (ac_q < 7'd16) begin
      cell_hit = 1'b1;
    end else if (row2_off < 8'd16) begin
      cell_hit = 1'b1;
      cell_idx = {1'b1, row2_off[3:0]};
    end
  end

  // Off-map addresses (0x28..0x3F, 0x68..0x7F) snap to the nearest line edge.
  always_comb begin
    if (entry_inc_q) begin
      if (ac_q >= LINE1_LAST && ac_q < LINE2_FIRST) begin
        ac_step = LINE2_FIRST;
      end else if (ac_q >= LINE2_LAST) begin
        ac_step = 7'h00;
      end else begin
        ac_step = ac_q + 7'd1;
      end
    end else begin
      if (ac_q > LINE1_LAST && ac_q <= LINE2_FIRST) begin
        ac_step = LINE1_LAST;
      end else if (ac_q == 7'h00 || ac_q > LINE2_LAST) begin
        ac_step = LINE2_LAST;
      end else begin
        ac_step = ac_q - 7'd1;
      end
    end
  end

  always_comb begin
    valid_d      = valid_q;
    ac_d         = ac_q;
    disp_on_d    = disp_on_q;
    two_line_d   = two_line_q;
    eight_bit_d  = eight_bit_q;
    entry_inc_d  = entry_inc_q;
    frame_done_d = 1'b0;
    unsup_cmd_d  = unsup_cmd_q;
    bus_err_d    = bus_err_q;
    rd_data_d    = valid_q[rd_addr] ? mem[rd_addr] : BLANK_CHAR;

    if (rw_err) begin
      bus_err_d = 1'b1;
    end else if (cmd_wr) begin
      casez (db)
        8'b1???????: ac_d = db[6:0];
        8'b01??????: unsup_cmd_d = 1'b1;
        8'b001?????: begin
          eight_bit_d = db[4];
          two_line_d  = db[3];
        end
        8'b0001????: unsup_cmd_d = 1'b1;
        8'b00001???: disp_on_d = db[2];
        8'b000001??: entry_inc_d = db[1];
        8'b0000001?: ac_d = 7'h00;
        8'b00000001: begin
          valid_d     = '0;
          ac_d        = 7'h00;
          entry_inc_d = 1'b1;
        end
        default: ;
      endcase
    end else if (data_wr) begin
      if (cell_hit) begin
        valid_d[cell_idx] = 1'b1;
      end
      frame_done_d = (ac_q == ROW2_BASE + 7'd15);
      ac_d         = ac_step;
    end
  end

  // Character storage carries no reset; the valid mask hides stale contents.
  always_ff @(posedge clk_2ms) begin
    if (data_wr && cell_hit) begin
      mem[cell_idx] <= db;
    end
  end

  always_ff @(posedge clk_2ms or negedge rst) begin
    if (!rst) begin
      valid_q      <= '0;
      rd_data_q    <= BLANK_CHAR;
      ac_q         <= 7'h00;
      disp_on_q    <= 1'b0;
      two_line_q   <= 1'b0;
      eight_bit_q  <= 1'b1;
      entry_inc_q  <= 1'b1;
      frame_done_q <= 1'b0;
      unsup_cmd_q  <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      rd_data_q    <= rd_data_d;
      ac_q         <= ac_d;
      disp_on_q    <= disp_on_d;
      two_line_q   <= two_line_d;
      eight_bit_q  <= eight_bit_d;
      entry_inc_q  <= entry_inc_d;
      frame_done_q <= frame_done_d;
      unsup_cmd_q  <= unsup_cmd_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign ac         = ac_q;
  assign disp_on    = disp_on_q;
  assign two_line   = two_line_q;
  assign eight_bit  = eight_bit_q;
  assign entry_inc  = entry_inc_q;
  assign frame_done = frame_done_q;
  assign unsup_cmd  = unsup_cmd_q;
  assign bus_err    = bus_err_q;

endmodule

// File: doc/lcd1602_bus_responder.md
Name: lcd1602_bus_responder

Overview:
- Receive end of the HD44780-style 1602 write bus used by our LCD driver (RS, RW tied low, DB8, enable-select qualifier).
- Decodes the command/data byte stream and maintains a shadow 2x16 DDRAM plus controller state (address counter, entry mode, display on, function set).
- Used as a bench/debug model and as an on-chip readback monitor, so display contents can be checked without the glass.
- Single clock domain, clk_2ms, the same clock that launches DB8/RS.

Parameters:
- BLANK_CHAR, 8'h20, value read back for cleared or never-written cells
- ROW2_BASE, 7'h40, DDRAM address of row 2 column 0

Ports:
- clk_2ms  input  1  bus clock; bus sampled on rising edge
- rst  input  1  asynchronous, active-low reset
- lcd_en_sel  input  1  byte-valid qualifier; one byte transferred per clk_2ms cycle while high
- rs  input  1  0 = command, 1 = data
- rw  input  1  must be 0; a cycle with rw=1 and lcd_en_sel=1 is ignored and sets bus_err
- db  input  8  command/data byte
- rd_addr  input  5  readback index; [4] = row, [3:0] = column
- rd_data  output  8  readback character, 1-cycle latency
- ac  output  7  current address counter
- disp_on  output  1  display-on bit D
- two_line  output  1  function-set N bit
- eight_bit  output  1  function-set DL bit
- entry_inc  output  1  entry-mode I/D bit
- frame_done  output  1  1-cycle pulse on a data write to row 2 column 15
- unsup_cmd  output  1  sticky; an unsupported command was received
- bus_err  output  1  sticky; a byte was presented with rw=1

Behaviour:
- Reset (async assert, sync release):
  - ac=0, disp_on=0, two_line=0, eight_bit=1, entry_inc=1.
  - frame_done=0, unsup_cmd=0, bus_err=0, rd_data=BLANK_CHAR.
  - 32-bit valid mask cleared. RAM contents don't-care, because invalid cells read BLANK_CHAR.
- Cycles with lcd_en_sel=0: no state change except rd_data update; frame_done=0.
- Command decode (rs=0, rw=0, lcd_en_sel=1), by highest set bit of db:
  - 1xxxxxxx set DDRAM addr: ac<=db[6:0].
  - 01xxxxxx CGRAM addr: unsupported; unsup_cmd<=1, ac unchanged.
  - 001xxxxx function set: eight_bit<=db[4], two_line<=db[3].
  - 0001xxxx cursor/display shift: unsupported; unsup_cmd<=1.
  - 00001xxx display control: disp_on<=db[2].
  - 000001xx entry mode: entry_inc<=db[1]; S bit ignored.
  - 0000001x return home: ac<=0.
  - 00000001 clear: valid mask<=0, ac<=0, entry_inc<=1; completes in the same cycle, no busy state.
  - 00000000: ignored.
- Data write (rs=1, rw=0, lcd_en_sel=1):
  - If ac in 0x00..0x0F: cell {0,ac[3:0]} written, valid bit set.
  - If ac in ROW2_BASE..ROW2_BASE+15: cell {1,ac[3:0]} written, valid bit set.
  - Otherwise the data is discarded and ac still moves.
  - frame_done=1 in the following cycle iff the written address was ROW2_BASE+15.
- Address counter after a data write (HD44780 2-line map):
  - Increment: 0x27->0x40, 0x67->0x00, else +1.
  - Decrement: 0x40->0x27, 0x00->0x67, else -1.
  - Addresses 0x28..0x3F and 0x68..0x7F loaded by set-addr are accepted; the next increment goes to 0x40 / 0x00 respectively, and the next decrement goes to 0x27 / 0x67.
- Readback:
  - rd_data registered, = valid[rd_addr] ? ram[rd_addr] : BLANK_CHAR.
  - Same-cycle write to rd_addr: old value returned, new value on the next cycle.
- Back-to-back bytes every cycle must be accepted; no throughput limit, no busy flag.
- Reset mid-stream: all state returns to reset values immediately; the next byte after release is decoded normally.

Test Plan:
- Reset, then db 0x01, 0x38, 0x0C, 0x06 (rs=0) -> ac=0, two_line=1, eight_bit=1, disp_on=1, entry_inc=1, unsup_cmd=0; all 32 rd_data reads = 0x20.
- 0x80, then "STEP FPGA" + 7 spaces (rs=1), then 0xC0 + 16 bytes -> row 1 cells read back the exact ASCII; ac=0x50 after row 2; frame_done high exactly one cycle, after the 16th row-2 byte.
- Set ac=0x27 and write 2 bytes -> byte 1 discarded, byte 2 lands in row 2 col 0, ac=0x41. Set ac=0x67 and write 1 byte -> ac=0x00.
- 0x04 (decrement), ac=0x40, write 'A' -> cell row 2 col 0 = 0x41, ac=0x27. Write again -> discarded, ac=0x26.
- 0x40 and 0x18 commands -> unsup_cmd=1 and stays set, ac unchanged. A byte with rw=1 -> bus_err=1, RAM unchanged.
- Filled screen, then 0x01 -> all reads 0x20 the next cycle. Assert rst mid-row-2 write sequence -> outputs at reset values, frame_done never pulses.
